// File: rtl/flag_unit.sv
// Processor status-flag unit: N/V/D/I/Z/C register with a LIFO context stack.
// Ops are accepted on rising ph2 while op_valid is high; results are visible one edge later.
module flag_unit #(
   parameter int WIDTH    = 8,
   parameter int CONTEXTS = 4
) (
   input  logic                            ph2,
   input  logic                            reset,
   input  logic                            op_valid,
   input  logic [3:0]                      op,
   input  logic [WIDTH-1:0]                alu_result,
   input  logic                            alu_carry,
   input  logic                            alu_ovf,
   input  logic [3:0]                      upd_mask,
   input  logic [7:0]                      load_data,
   input  logic                            err_clear,
   output logic [7:0]                      status,
   output logic [$clog2(CONTEXTS+1)-1:0]   depth,
   output logic                            full,
   output logic                            empty,
   output logic                            err
);

   localparam int DW = $clog2(CONTEXTS + 1);
   localparam int IW = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1;

   // Packed flag order {N,V,D,I,Z,C}; status inserts the fixed 1/0 at bits 5/4.
   localparam int FN = 5;
   localparam int FV = 4;
   localparam int FD = 3;
   localparam int FI = 2;
   localparam int FZ = 1;
   localparam int FC = 0;

   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,
      OP_CLC     = 4'd1,
      OP_SEC     = 4'd2,
      OP_CLI     = 4'd3,
      OP_SEI     = 4'd4,
      OP_CLV     = 4'd5,
      OP_CLD     = 4'd6,
      OP_SED     = 4'd7,
      OP_ALU     = 4'd8,
      OP_LOAD    = 4'd9,
      OP_SAVE    = 4'd10,
      OP_RESTORE = 4'd11
   } op_e;

   logic [5:0]    flags_q, flags_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          err_q, err_d;
   logic [5:0]    stack_q [CONTEXTS];

   logic          push_s;
   logic          new_err_s;
   logic [IW-1:0] push_idx_s;
   logic [IW-1:0] top_idx_s;
   logic [5:0]    top_s;

   // Next-state decode for flags, stack pointer and the sticky error.
   always_comb begin
      flags_d    = flags_q;
      depth_d    = depth_q;
      push_s     = 1'b0;
      new_err_s  = 1'b0;
      push_idx_s = IW'(depth_q);
      top_idx_s  = IW'(depth_q - DW'(1));
      top_s      = stack_q[top_idx_s];

      if (op_valid) begin
         case (op_e'(op))
            OP_CLC: flags_d[FC] = 1'b0;
            OP_SEC: flags_d[FC] = 1'b1;
            OP_CLI: flags_d[FI] = 1'b0;
            OP_SEI: flags_d[FI] = 1'b1;
            OP_CLV: flags_d[FV] = 1'b0;
            OP_CLD: flags_d[FD] = 1'b0;
            OP_SED: flags_d[FD] = 1'b1;
            OP_ALU: begin
               flags_d[FN] = upd_mask[3] ? alu_result[WIDTH-1]           : flags_q[FN];
               flags_d[FV] = upd_mask[2] ? alu_ovf                       : flags_q[FV];
               flags_d[FZ] = upd_mask[1] ? (alu_result == {WIDTH{1'b0}}) : flags_q[FZ];
               flags_d[FC] = upd_mask[0] ? alu_carry                     : flags_q[FC];
            end
            OP_LOAD: flags_d = {load_data[7:6], load_data[3:0]};
            OP_SAVE: begin
               flags_d[FI] = 1'b1;
               if (!full_q) begin
                  push_s  = 1'b1;
                  depth_d = depth_q + DW'(1);
               end else begin
                  new_err_s = 1'b1;
               end
            end
            OP_RESTORE: begin
               if (!empty_q) begin
                  flags_d = top_s;
                  depth_d = depth_q - DW'(1);
               end else begin
                  new_err_s = 1'b1;
               end
            end
            default: flags_d = flags_q;
         endcase
      end else begin
         flags_d = flags_q;
      end

      full_d  = (depth_d == DW'(CONTEXTS));
      empty_d = (depth_d == DW'(0));
      // A fresh error wins over a simultaneous clear.
      err_d   = new_err_s | (err_q & ~err_clear);
   end

   // Architectural state; reset leaves interrupts masked and the stack empty.
   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         flags_q <= 6'b000100;
         depth_q <= DW'(0);
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         depth_q <= depth_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   // Stack storage needs no reset: entries at or above depth are never read.
   always_ff @(posedge ph2) begin
      if (push_s) begin
         stack_q[push_idx_s] <= flags_q;
      end
   end

   assign status = {flags_q[FN], flags_q[FV], 2'b10, flags_q[FD], flags_q[FI], flags_q[FZ], flags_q[FC]};
   assign depth  = depth_q;
   assign full   = full_q;
   assign empty  = empty_q;
   assign err    = err_q;

endmodule
